// File: rtl/dsm_cic_decimator.sv
// Third-order CIC decimator (M=1) for the modulator's ternary pwm stream.
// One signed OUT_W-bit sample is produced every 2^DEC_LOG2 enabled cycles.
module dsm_cic_decimator #(
  parameter int DEC_LOG2 = 3,
  parameter int OUT_W    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              pwm,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  output logic                    code_err
);

  localparam int W     = 2 + 3 * DEC_LOG2;
  localparam int SHIFT = OUT_W - 1 - 3 * DEC_LOG2;

  localparam logic signed [OUT_W:0] MAX_V = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W:0] MIN_V = {2'b11, {(OUT_W-1){1'b0}}};

  generate
    if (3 * DEC_LOG2 > OUT_W - 1) begin : g_bad_width
      $error("dsm_cic_decimator: 3*DEC_LOG2 must not exceed OUT_W-1");
    end
  endgenerate

  logic signed [W-1:0]     x_d, x_q;
  logic signed [W-1:0]     int1_q, int2_q, int3_q;
  logic signed [W-1:0]     d1_q, d2_q, d3_q;
  logic signed [W-1:0]     c1, c2, c3;
  logic [DEC_LOG2-1:0]     phase_q;
  logic                    illegal;
  logic                    block_end;
  logic signed [OUT_W:0]   ext, shifted;
  logic signed [OUT_W-1:0] dout_d, dout_q;
  logic                    dout_valid_q;
  logic                    code_err_q;

  always_comb begin
    x_d     = '0;
    illegal = 1'b0;
    case (pwm)
      2'b01:   x_d = W'(1);
      2'b11:   x_d = '1;
      2'b10:   illegal = 1'b1;
      default: x_d = '0;
    endcase
  end

  // Combs see int3 only on the last phase of each block; wrap is intentional.
  always_comb begin
    block_end = (phase_q == {DEC_LOG2{1'b1}});
    c1        = int3_q - d1_q;
    c2        = c1 - d2_q;
    c3        = c2 - d3_q;
    ext       = (OUT_W+1)'(c3);
    shifted   = ext <<< SHIFT;
    if (shifted > MAX_V) begin
      dout_d = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      dout_d = MIN_V[OUT_W-1:0];
    end else begin
      dout_d = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_q          <= '0;
      int1_q       <= '0;
      int2_q       <= '0;
      int3_q       <= '0;
      phase_q      <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
    end else if (enable) begin
      x_q     <= x_d;
      int1_q  <= int1_q + x_q;
      int2_q  <= int2_q + int1_q;
      int3_q  <= int3_q + int2_q;
      phase_q <= phase_q + DEC_LOG2'(1);
      if (illegal) begin
        code_err_q <= 1'b1;
      end
      if (block_end) begin
        d1_q         <= int3_q;
        d2_q         <= c1;
        d3_q         <= c2;
        dout_q       <= dout_d;
        dout_valid_q <= 1'b1;
      end else begin
        dout_valid_q <= 1'b0;
      end
    end else begin
      dout_valid_q <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Directed bench for dsm_cic_decimator with hand-computed CIC step responses.
module tb_dsm_cic_decimator;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [1:0]         pwm;
  logic signed [14:0] dout;
  logic               dout_valid;
  logic               code_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic signed [14:0] got_q[$];
  int                 t_q[$];
  logic [14:0]        exp_q[$];
  int                 exp_t[$];

  dsm_cic_decimator #(.DEC_LOG2(3), .OUT_W(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pwm        (pwm),
    .dout       (dout),
    .dout_valid (dout_valid),
    .code_err   (code_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (dout_valid === 1'b1) begin
      got_q.push_back(dout);
      t_q.push_back(cyc);
    end
  endtask

  task automatic run(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      pwm = code;
      step();
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b1;
    pwm    = 2'b00;
    step();
    reset = 1'b1;
    cyc   = 0;
    got_q.delete();
    t_q.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b1;
    pwm    = 2'b10;
    step();
    step();
    vectors++;
    if (dout !== 15'sd0) begin
      miscompares++;
      $display("FAIL reset_dout: got %0d required 0", dout);
    end
    vectors++;
    if (dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b required 0", dout_valid);
    end
    vectors++;
    if (code_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_code_err: got %b required 0", code_err);
    end
  endtask

  task automatic test_zero();
    do_reset();
    run(2'b00, 64);
    vectors++;
    if (got_q.size() !== 8) begin
      miscompares++;
      $display("FAIL zero_count: got %0d strobes required 8", got_q.size());
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== 15'sd0 || t_q[i] !== 8 * (i + 1)) begin
        miscompares++;
        $display("FAIL zero_sample%0d: got %0d at cycle %0d required 0 at cycle %0d",
                 i, got_q[i], t_q[i], 8 * (i + 1));
      end
    end
    vectors++;
    if (code_err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_code_err: got %b required 0", code_err);
    end
  endtask

  task automatic check_step(input string name, input int n);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d strobes required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = n; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i] || t_q[i] !== exp_t[i]) begin
        miscompares++;
        $display("FAIL %s_sample%0d: got %0d at cycle %0d required %0d at cycle %0d",
                 name, i, got_q[i], t_q[i], $signed(exp_q[i]), exp_t[i]);
      end
    end
  endtask

  task automatic test_pos();
    do_reset();
    run(2'b01, 40);
    exp_q = '{15'sd640, 15'sd9728, 15'sd16256, 15'sd16383, 15'sd16383};
    exp_t = '{8, 16, 24, 32, 40};
    check_step("pos", 0);
  endtask

  task automatic test_neg();
    do_reset();
    run(2'b11, 40);
    exp_q = '{-15'sd640, -15'sd9728, -15'sd16256, -15'sd16384, -15'sd16384};
    exp_t = '{8, 16, 24, 32, 40};
    check_step("neg", 0);
  endtask

  task automatic test_alt();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      pwm = (i % 2 == 0) ? 2'b01 : 2'b11;
      step();
    end
    exp_q = '{15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0};
    exp_t = '{8, 16, 24, 32, 40};
    check_step("alt", 3);
  endtask

  task automatic test_code_err();
    do_reset();
    run(2'b00, 10);
    vectors++;
    if (code_err !== 1'b0) begin
      miscompares++;
      $display("FAIL code_err_before: got %b required 0", code_err);
    end
    run(2'b10, 1);
    vectors++;
    if (code_err !== 1'b1) begin
      miscompares++;
      $display("FAIL code_err_rise: got %b required 1", code_err);
    end
    run(2'b00, 29);
    exp_q = '{15'sd0, 15'sd0, 15'sd0, 15'sd0, 15'sd0};
    exp_t = '{8, 16, 24, 32, 40};
    check_step("code_err_dout", 0);
    vectors++;
    if (code_err !== 1'b1) begin
      miscompares++;
      $display("FAIL code_err_sticky: got %b required 1", code_err);
    end
    do_reset();
    vectors++;
    if (code_err !== 1'b0) begin
      miscompares++;
      $display("FAIL code_err_clear: got %b required 0", code_err);
    end
  endtask

  task automatic test_gate();
    int seg_en[5]  = '{1, 0, 1, 0, 1};
    int seg_len[5] = '{16, 2, 4, 3, 20};
    do_reset();
    pwm = 2'b01;
    for (int s = 0; s < 5; s++) begin
      enable = seg_en[s][0];
      for (int i = 0; i < seg_len[s]; i++) step();
    end
    enable = 1'b1;
    exp_q = '{15'sd640, 15'sd9728, 15'sd16256, 15'sd16383, 15'sd16383};
    exp_t = '{8, 16, 29, 37, 45};
    check_step("gate", 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(2'b01, 12);
    reset = 1'b0;
    step();
    vectors++;
    if (dout !== 15'sd0 || dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_out: got dout %0d valid %b required 0 and 0", dout, dout_valid);
    end
    reset = 1'b1;
    cyc   = 0;
    got_q.delete();
    t_q.delete();
    run(2'b01, 16);
    exp_q = '{15'sd640, 15'sd9728};
    exp_t = '{8, 16};
    check_step("mid_reset", 0);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_pos();
    test_neg();
    test_alt();
    test_code_err();
    test_gate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsm_cic_decimator.md
Name: dsm_cic_decimator

Overview:
- Downstream consumer of the delta-sigma modulator's ternary `pwm` stream.
- Third-order CIC decimator (differential delay 1) that reconstructs a signed OUT_W-bit sample from every 2^DEC_LOG2 modulator outputs.
- Used for in-fabric loopback checking of the modulator and as the basis for SNR measurement against the modulator input.

Parameters:
- DEC_LOG2, 3, log2 of decimation ratio R. Default R = 8, matching the 8:1 fast-clock to sample-clock ratio.
- OUT_W, 15, output sample width, signed; same format as the modulator input.

Ports:
- clock  in  1  fast modulator clock.
- reset  in  1  synchronous, active-low.
- enable  in  1  when low, the whole pipeline, phase counter and outputs hold.
- pwm  in  2  modulator code: 01 = +1, 11 = -1, 00 = 0, 10 = illegal.
- dout  out  OUT_W  decimated sample, signed two's complement.
- dout_valid  out  1  single-cycle strobe, once per R enabled cycles.
- code_err  out  1  sticky flag; set when an illegal code is sampled.

Behaviour:
- Reset (reset == 0 at a rising edge):
  - All registers clear to zero: input register, 3 integrators, phase counter, 3 comb delay registers, dout, dout_valid, code_err.
  - Reset has priority over enable.
  - Reset mid-block discards the partial block; the first post-reset strobe follows a full R enabled cycles.
- Decode: pwm maps to x in {+1, 0, -1}, sign-extended to internal width W = 2 + 3*DEC_LOG2 (11 for defaults).
  - Code 10 decodes as 0 and sets code_err on the same edge. code_err stays set until reset.
- Enable gating: every register below updates only on edges where enable == 1. Latencies are counted in enabled cycles.
- Pipeline, per enabled edge:
  - E0: x registered into x_q.
  - int1 += x_q; int2 += int1; int3 += int2. Each integrator is a registered stage, so the chain has a fixed 1-cycle skew per stage.
- Integrator arithmetic:
  - All integrators are W bits and wrap modulo 2^W. No saturation is allowed, because the CIC requires two's-complement wrap.
- Phase counter:
  - DEC_LOG2 bits, increments every enabled edge and wraps R-1 -> 0.
  - On the enabled edge where phase == R-1, the current int3 is the decimated value.
- Comb stage, on that edge:
  - c1 = int3 - d1; c2 = c1 - d2; c3 = c2 - d3, all evaluated combinationally in W bits with modulo wrap.
  - d1 <= int3, d2 <= c1, d3 <= c2.
  - dout <= scale(c3); dout_valid <= 1.
  - On every other enabled edge, dout_valid <= 0 and dout holds its value.
  - When enable == 0, dout_valid <= 0.
- Scaling:
  - CIC gain is R^3 = 2^(3*DEC_LOG2).
  - scale(c3) = c3 sign-extended to OUT_W+1 bits, then shifted left by OUT_W-1-3*DEC_LOG2 (5 for defaults), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Full-scale +1 therefore gives 16383 (saturated) and full-scale -1 gives -16384.
  - Elaboration error if 3*DEC_LOG2 > OUT_W-1.
- dout_valid cadence:
  - Exactly one high cycle per R enabled cycles.
  - The first strobe is on the R-th enabled edge after reset release.
- Transients: the first 3 outputs after reset are the deterministic CIC step transient with zero-initialised history. Outputs from the 4th onward are steady-state.

Test Plan:
- pwm held 00 for 64 enabled cycles after reset -> 8 dout_valid strobes spaced exactly 8 cycles apart; every dout = 0; code_err = 0.
- pwm held 01 continuously -> 4th and later dout = 16383 (saturated); pwm held 11 -> 4th and later dout = -16384.
- pwm alternating 01/11 every cycle -> 4th and later dout = 0.
- Single 10 code injected mid-stream of 00 -> code_err rises on the next edge and stays 1; dout unaffected (0); code_err clears only on reset.
- enable low for 5 cycles in the middle of a block of 01 -> no dout_valid during the gap; the next strobe is delayed by exactly 5 cycles; dout sequence is identical to the ungated run.
- reset asserted for 1 cycle mid-block during a 01 stream -> next cycle dout = 0, dout_valid = 0; the first post-reset strobe arrives 8 enabled cycles after release and repeats the from-reset step transient.
